sram_port_arbiter: RTL and testbench

Two-master arbiter that shares a single sram-like memory port between the CPU instruction-fetch interface and the data (load/store) interface. It sits between the pipeline's `inst_*`/`data_*` sram-like ports and the one downstream sram-like slave, typically an AXI bridge or a unified cache. It sequences one transaction at a time with a grant FSM and routes `addr_ok`, `data_ok` and `rdata` back to the master that owns the transaction.

---
 rtl/sram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like slave port between the inst and data masters.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-first.
module sram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   gnt;
  logic   gnt_sel;
  logic   any_req;
  logic   take;

  assign any_req = inst_req | data_req;
  assign take    = (state == S_ARB) & any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;

  // On a tie the master not served last wins.
  always_comb begin
    gnt_sel = data_req;
    if (inst_req && data_req)
      gnt_sel = ~rr_last;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      rr_last <= 1'b1;
    else if (take)
      rr_last <= gnt_sel;
  end
`else
  // Data first so a blocked load/store is never starved by fetch.
  always_comb begin
    gnt_sel = data_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn)
      state <= S_ARB;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      gnt <= 1'b0;
    else if (take)
      gnt <= gnt_sel;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ARB:  if (any_req)   state_nxt = S_ADDR;
      S_ADDR: if (m_addr_ok) state_nxt = S_WAIT;
      S_WAIT: if (m_data_ok) state_nxt = S_ARB;
      default:               state_nxt = S_ARB;
    endcase
  end

  always_comb begin
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = '0;
    m_addr       = '0;
    m_wdata      = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state)
      S_ADDR: begin
        m_req        = 1'b1;
        m_wr         = gnt ? data_wr    : inst_wr;
        m_size       = gnt ? data_size  : inst_size;
        m_addr       = gnt ? data_addr  : inst_addr;
        m_wdata      = gnt ? data_wdata : inst_wdata;
        inst_addr_ok = ~gnt & m_addr_ok;
        data_addr_ok =  gnt & m_addr_ok;
      end
      // Responses outside WAIT are slave errors and never reach a master.
      S_WAIT: begin
        inst_data_ok = ~gnt & m_data_ok;
        data_data_ok =  gnt & m_data_ok;
      end
      default: ;
    endcase
  end

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; expectations follow the
// build's tie policy (ARB_ROUND_ROBIN_EN or fixed data-first).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    cyc();
    cyc();
    resetn = 1;
  endtask

  task automatic test_reset();
    logic [6:0] st;
    clear_inputs();
    resetn = 0;
    cyc();
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    st = {m_req, m_wr, inst_addr_ok, data_addr_ok, inst_data_ok,
          data_data_ok, |{m_size, m_addr, m_wdata}};
    checks++;
    if (st !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000000", st);
    end
    cyc();
    resetn = 1;
    m_addr_ok = 0; m_data_ok = 0;
  endtask

  task automatic test_single_inst();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2; m_addr_ok = 1;
    #1;
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL single_c0_mreq got %b want 0", m_req);
    end
    cyc();
    checks++;
    if ({m_req, m_wr, inst_addr_ok, data_addr_ok} !== 4'b1010 ||
        m_addr !== 32'hBFC0_0000 || m_size !== 2'd2) begin
      errors++;
      $display("FAIL single_c1 got req/wr/iok/dok=%b%b%b%b addr=%h size=%0d want 1010 bfc00000 2",
               m_req, m_wr, inst_addr_ok, data_addr_ok, m_addr, m_size);
    end
    cyc();
    inst_req = 0;
    #1;
    checks++;
    if ({m_req, inst_data_ok, data_data_ok} !== 3'b000) begin
      errors++;
      $display("FAIL single_c2 got %b want 000", {m_req, inst_data_ok, data_data_ok});
    end
    cyc();
    m_data_ok = 1; m_rdata = 32'h3C1D_0000;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, data_addr_ok} !== 3'b100 ||
        inst_rdata !== 32'h3C1D_0000) begin
      errors++;
      $display("FAIL single_c3 got ok=%b rdata=%h want 100 3c1d0000",
               {inst_data_ok, data_data_ok, data_addr_ok}, inst_rdata);
    end
    cyc();
    m_data_ok = 0;
    #1;
    checks++;
    if ({m_req, inst_data_ok} !== 2'b00) begin
      errors++; $display("FAIL single_c4 got %b want 00", {m_req, inst_data_ok});
    end
  endtask

  task automatic test_tie();
    logic        fd;
    logic [31:0] a1, a2, w1;
`ifdef ARB_ROUND_ROBIN_EN
    fd = 1'b0;
`else
    fd = 1'b1;
`endif
    a1 = fd ? 32'h200 : 32'h100;
    a2 = fd ? 32'h100 : 32'h200;
    w1 = fd ? 32'hDEAD_BEEF : 32'h0;
    do_reset();
    inst_req = 1; inst_addr = 32'h100; inst_wdata = 0;
    data_req = 1; data_wr = 1; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF;
    m_addr_ok = 1;
    cyc();
    checks++;
    if ({m_req, m_wr, inst_addr_ok, data_addr_ok} !== {1'b1, fd, ~fd, fd} ||
        m_addr !== a1 || m_wdata !== w1) begin
      errors++;
      $display("FAIL tie_first got %b addr=%h wdata=%h want %b %h %h",
               {m_req, m_wr, inst_addr_ok, data_addr_ok}, m_addr, m_wdata,
               {1'b1, fd, ~fd, fd}, a1, w1);
    end
    cyc();
    if (fd) data_req = 0; else inst_req = 0;
    m_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== {~fd, fd}) begin
      errors++;
      $display("FAIL tie_first_resp got %b want %b",
               {inst_data_ok, data_data_ok}, {~fd, fd});
    end
    cyc();
    m_data_ok = 0;
    #1;
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL tie_gap got m_req=%b want 0", m_req);
    end
    cyc();
    checks++;
    if ({m_req, m_wr, inst_addr_ok, data_addr_ok} !== {1'b1, ~fd, fd, ~fd} ||
        m_addr !== a2) begin
      errors++;
      $display("FAIL tie_second got %b addr=%h want %b %h",
               {m_req, m_wr, inst_addr_ok, data_addr_ok}, m_addr,
               {1'b1, ~fd, fd, ~fd}, a2);
    end
    cyc();
    inst_req = 0; data_req = 0;
    m_data_ok = 1;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== {fd, ~fd}) begin
      errors++;
      $display("FAIL tie_second_resp got %b want %b",
               {inst_data_ok, data_data_ok}, {fd, ~fd});
    end
    cyc();
    m_data_ok = 0;
  endtask

  task automatic test_back_to_back();
    logic isd;
    do_reset();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_addr = 32'h200;
    m_addr_ok = 1;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      isd = (i % 2) == 1;
`else
      isd = 1'b1;
`endif
      #1;
      checks++;
      if (m_req !== 1'b0) begin
        errors++; $display("FAIL b2b_arb%0d got m_req=%b want 0", i, m_req);
      end
      cyc();
      checks++;
      if ({m_req, inst_addr_ok, data_addr_ok} !== {1'b1, ~isd, isd} ||
          m_addr !== (isd ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL b2b_grant%0d got %b addr=%h want %b %h", i,
                 {m_req, inst_addr_ok, data_addr_ok}, m_addr,
                 {1'b1, ~isd, isd}, isd ? 32'h200 : 32'h100);
      end
      cyc();
      m_data_ok = 1;
      #1;
      checks++;
      if ({inst_data_ok, data_data_ok} !== {~isd, isd}) begin
        errors++;
        $display("FAIL b2b_resp%0d got %b want %b", i,
                 {inst_data_ok, data_data_ok}, {~isd, isd});
      end
      cyc();
      m_data_ok = 0;
    end
    inst_req = 0; data_req = 0;
  endtask

  task automatic test_stall();
    do_reset();
    data_req = 1; data_wr = 1; data_addr = 32'h300; data_wdata = 32'h1234_5678;
    m_addr_ok = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin inst_req = 1; inst_addr = 32'h400; end
      #1;
      checks++;
      if ({m_req, inst_addr_ok, data_addr_ok} !== 3'b100 ||
          m_addr !== 32'h300 || m_wdata !== 32'h1234_5678) begin
        errors++;
        $display("FAIL stall%0d got %b addr=%h wdata=%h want 100 300 12345678",
                 i, {m_req, inst_addr_ok, data_addr_ok}, m_addr, m_wdata);
      end
      cyc();
    end
    m_addr_ok = 1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL stall_accept got %b want 01", {inst_addr_ok, data_addr_ok});
    end
    cyc();
    data_req = 0;
    #1;
    checks++;
    if ({m_req, inst_addr_ok} !== 2'b00) begin
      errors++; $display("FAIL stall_wait got %b want 00", {m_req, inst_addr_ok});
    end
    cyc();
    m_data_ok = 1;
    #1;
    checks++;
    if ({m_req, inst_data_ok, data_data_ok} !== 3'b001) begin
      errors++;
      $display("FAIL stall_resp got %b want 001", {m_req, inst_data_ok, data_data_ok});
    end
    cyc();
    m_data_ok = 0;
    cyc();
    checks++;
    if ({m_req, inst_addr_ok} !== 2'b11 || m_addr !== 32'h400) begin
      errors++;
      $display("FAIL stall_inst got %b addr=%h want 11 400",
               {m_req, inst_addr_ok}, m_addr);
    end
    cyc();
    inst_req = 0;
    m_data_ok = 1;
    cyc();
    m_data_ok = 0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    inst_req = 1; inst_addr = 32'h500; m_addr_ok = 1;
    cyc();
    cyc();
    inst_req = 0;
    resetn = 0;
    cyc();
    resetn = 1;
    m_data_ok = 1; m_rdata = 32'hAAAA_5555;
    #1;
    checks++;
    if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL rst_wait got %b want 00000",
               {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    cyc();
    m_data_ok = 0;
    #1;
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL rst_wait_idle got m_req=%b want 0", m_req);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    m_data_ok = 1;
    #1;
    checks++;
    if ({m_req, inst_data_ok, data_data_ok} !== 3'b000) begin
      errors++;
      $display("FAIL spur_resp got %b want 000", {m_req, inst_data_ok, data_data_ok});
    end
    cyc();
    m_data_ok = 0;
    data_req = 1; data_addr = 32'h600; m_addr_ok = 1;
    cyc();
    checks++;
    if ({m_req, data_addr_ok} !== 2'b11 || m_addr !== 32'h600) begin
      errors++;
      $display("FAIL spur_arb got %b addr=%h want 11 600", {m_req, data_addr_ok}, m_addr);
    end
    cyc();
    data_req = 0;
    m_data_ok = 1;
    cyc();
    m_data_ok = 0;
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    test_reset();
    test_single_inst();
    test_tie();
    test_back_to_back();
    test_stall();
    test_reset_in_wait();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
